// File: rtl/cpc_bus_slot_arbiter.sv
// CPC bus-slot sequencer: SLOTS-phase bus period with video, round-robin aux and CPU slots.
// Optional stall counter enabled by defining CPC_ARB_STALL_CNT_EN.
module cpc_bus_slot_arbiter #(
    parameter int unsigned SLOTS     = 4,
    parameter int unsigned AUX_CH    = 2,
    parameter int unsigned CPU_PHASE = SLOTS - 1,
    localparam int unsigned PW       = $clog2(SLOTS)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              ce,
    input  logic              resync,
    input  logic              no_wait,
    input  logic              cpu_req,
    output logic              cpu_wait_n,
    output logic              cpu_ack,
    output logic              vid_slot,
    input  logic [AUX_CH-1:0] aux_req,
    output logic [AUX_CH-1:0] aux_gnt,
    output logic [PW-1:0]     phase,
    output logic [15:0]       stall_cnt,
    input  logic              stall_clr
);

    localparam int unsigned RW = (AUX_CH > 1) ? $clog2(AUX_CH) : 1;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;

    logic [PW-1:0]     phase_q, phase_d, phase_ld;
    logic [RW-1:0]     rr_q, rr_d;
    logic [AUX_CH-1:0] gnt_q, gnt_d;
    logic [1:0]        state_q, state_d;
    logic              vid_q, vid_d;
    logic              ack_q, ack_d;
    logic              found;
    int                idx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            rr_q    <= '0;
            gnt_q   <= '0;
            state_q <= ST_IDLE;
            vid_q   <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            phase_q <= phase_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            state_q <= state_d;
            vid_q   <= vid_d;
            ack_q   <= ack_d;
        end
    end

    always_comb begin
        phase_d = phase_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        state_d = state_q;
        vid_d   = 1'b0;
        ack_d   = 1'b0;
        found   = 1'b0;
        idx     = 0;

        // Phase the pending ce would load; only committed when ce is high.
        if (resync || phase_q == PW'(SLOTS - 1)) begin
            phase_ld = '0;
        end else begin
            phase_ld = phase_q + PW'(1);
        end

        if (ce) begin
            phase_d = phase_ld;
            vid_d   = (phase_ld == '0);
            gnt_d   = '0;
            if (phase_ld == PW'(1)) begin
                for (int i = 0; i < int'(AUX_CH); i++) begin
                    idx = (int'(rr_q) + i) % int'(AUX_CH);
                    if (!found && ((aux_req >> idx) & AUX_CH'(1)) != '0) begin
                        found = 1'b1;
                        gnt_d = AUX_CH'(1) << idx;
                        rr_d  = RW'((idx + 1) % int'(AUX_CH));
                    end
                end
            end
        end

        // An aborted cycle in WAIT takes priority over a simultaneous release.
        case (state_q)
            ST_IDLE: begin
                if (cpu_req) state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (!cpu_req) begin
                    state_d = ST_IDLE;
                end else if (ce && phase_ld == PW'(CPU_PHASE)) begin
                    state_d = ST_ACCESS;
                    ack_d   = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (!cpu_req) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign phase      = phase_q;
    assign aux_gnt    = gnt_q;
    assign vid_slot   = vid_q;
    assign cpu_ack    = ack_q;
    assign cpu_wait_n = (state_q != ST_WAIT) | no_wait;

`ifdef CPC_ARB_STALL_CNT_EN
    logic [15:0] stall_q, stall_d;

    // Saturating count of clk cycles spent stalled; clear wins over increment.
    always_comb begin
        stall_d = stall_q;
        if (stall_clr) begin
            stall_d = '0;
        end else if (state_q == ST_WAIT && stall_q != 16'hFFFF) begin
            stall_d = stall_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end

    assign stall_cnt = stall_q;
`else
    logic stall_clr_unused;
    assign stall_clr_unused = stall_clr;
    assign stall_cnt        = 16'h0000;
`endif

endmodule

// File: doc/cpc_bus_slot_arbiter.md
# cpc_bus_slot_arbiter

Parametrised bus-slot sequencer for the CPC motherboard. It generalises the fixed 1 MHz CPU wait-state stretch into a configurable SLOTS-phase bus period. Each period carries one video fetch slot, one auxiliary slot shared round-robin by AUX_CH requesters (DMA, disk, sound), and CPU slots. It sits between the T80 bus strobes, the Gate Array video fetch and the SDRAM port mux, and drives the CPU wait line.

## Interface
Parameters:
- SLOTS, 4, ce ticks per bus period (legal 3..16); phase width PW = $clog2(SLOTS)
- AUX_CH, 2, number of auxiliary requesters (legal 1..8)
- CPU_PHASE, SLOTS-1, phase in which a waiting CPU access is released

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- ce  in  1  slot-advance enable (ce_4p rate), one clk wide
- resync  in  1  sampled on ce; forces phase to 0 on that ce
- no_wait  in  1  turbo: forces cpu_wait_n high
- cpu_req  in  1  CPU memory or IO cycle active (~MREQ_n | ~IORQ_n)
- cpu_wait_n  out  1  CPU WAIT, low = stall
- cpu_ack  out  1  one-clk pulse when the CPU access is released
- vid_slot  out  1  one-clk pulse at start of video slot
- aux_req  in  AUX_CH  level requests
- aux_gnt  out  AUX_CH  one-hot grant, held for one ce period
- phase  out  PW  current slot phase
- stall_cnt  out  16  CPU stall counter (see Configuration)
- stall_clr  in  1  clears stall_cnt

## Operation
- Phase counter: advances on each ce, 0..SLOTS-1, wraps to 0. resync=1 on a ce loads 0 instead of incrementing. Phase 0 = video, phase 1 = aux, all other phases = CPU.
- vid_slot: pulses in the clk following a ce that loads phase 0, including a resync load.
- Aux arbiter: on a ce loading phase 1, if any aux_req is high, grant the first requesting index at or after pointer rr (wrapping mod AUX_CH). rr then becomes granted+1 mod AUX_CH. aux_gnt holds until the next ce, then clears. With no request, aux_gnt stays 0 and rr is unchanged. A request dropped while granted keeps its grant to the end of the slot.
- CPU FSM:
  - IDLE: cpu_req=1 -> WAIT.
  - WAIT: on a ce loading CPU_PHASE -> ACCESS, with one cpu_ack pulse.
  - ACCESS: cpu_req=0 -> IDLE.
  - A request arriving in the same clk as the CPU_PHASE ce still enters WAIT and waits a full period.
  - cpu_req dropping in WAIT (aborted cycle) -> IDLE, no ack.
- cpu_wait_n = ~(state==WAIT) | no_wait. This output is combinational from the state only. With no_wait=1 the FSM still runs and cpu_ack still pulses.
- Reset clears everything: phase=0, state=IDLE, rr=0, aux_gnt=0, vid_slot=0, cpu_ack=0, cpu_wait_n=1, stall_cnt=0. Reset asserted mid-access drops the grant and the wait immediately.

## Timing
- cpu_wait_n falls in the clk after cpu_req is first seen high. Worst-case stall is SLOTS ce periods. Best case is one ce period, when the request arrives just before the ce into CPU_PHASE.
- cpu_ack and the release of cpu_wait_n occur in the same clk, one clk after the releasing ce.
- aux_gnt is valid from 1 clk after the phase-1 ce to 1 clk after the next ce.
- ce=0 freezes phase, grants and WAIT. stall_cnt counts clk cycles spent in WAIT regardless of ce.

## Configuration
- CPC_ARB_STALL_CNT_EN defined:
  - stall_cnt is a 16-bit saturating counter, +1 per clk in WAIT, holding at 0xFFFF.
  - stall_clr has priority over increment.
- Not defined: stall_cnt is tied to 0, stall_clr is ignored, and no counter logic is built.

## Test plan
- Reset release, SLOTS=4, continuous ce -> phase goes 0,1,2,3,0; vid_slot pulses once per 4 ce; cpu_wait_n=1.
- cpu_req rises just after the phase-0 ce -> cpu_wait_n low for 3 ce periods; cpu_ack pulses after the phase-3 ce; wait releases in the same clk.
- AUX_CH=3, aux_req=3'b111 held -> over successive periods aux_gnt goes 001, 010, 100, 001; aux_req=3'b100 only -> 100 every period.
- resync pulsed while phase=2 -> next ce loads phase 0; vid_slot pulses; a CPU request in WAIT stays stalled until the following phase-3 ce.
- no_wait=1 with a pending request -> cpu_wait_n stays 1 throughout; cpu_ack still pulses at CPU_PHASE; with the macro defined, stall_cnt still increments. Then reset_n low mid-WAIT -> all outputs return to their reset values asynchronously.
- Macro defined, cpu_req held with ce stopped for 70000 clk -> stall_cnt=0xFFFF; stall_clr=1 for 1 clk -> 0.
